// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryption core: one round per clock with on-the-fly key expansion.
// The result register holds the ciphertext until the next completion or reset.
module aes_encrypt_core #(
    parameter int NR = 10
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Run,
    input  logic [127:0] Plaintext,
    input  logic [127:0] Cipherkey,
    output logic [127:0] Ciphertext,
    output logic         Ready,
    output logic         Busy
);

    if (NR != 10) begin : g_nr_check
        $error("aes_encrypt_core supports only NR=10 (AES-128)");
    end

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    fsm_t         fsm_reg, fsm_next;
    logic [127:0] blk_reg;
    logic [127:0] key_reg;
    logic [127:0] ct_reg;
    logic [3:0]   rnd_reg;

    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [127:0] nk;
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   mc [16];
    logic [127:0] round_out;
    logic         last_round;

    assign last_round = (rnd_reg == 4'(NR));

    // Key schedule: RotWord of the last key word, then four S-box lookups.
    assign rot_word = {key_reg[23:0], key_reg[31:24]};

    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
        assign sub_word[31-8*gi -: 8] = SBOX[rot_word[31-8*gi -: 8]];
    end

    assign nk[127:96] = key_reg[127:96] ^ sub_word ^ {rcon(rnd_reg), 24'h0};
    assign nk[95:64]  = key_reg[95:64]  ^ nk[127:96];
    assign nk[63:32]  = key_reg[63:32]  ^ nk[95:64];
    assign nk[31:0]   = key_reg[31:0]   ^ nk[63:32];

    for (genvar gi = 0; gi < 16; gi++) begin : g_subbytes
        assign sb[gi] = SBOX[blk_reg[127-8*gi -: 8]];
    end

    // Byte gi sits at row gi%4, column gi/4; row r rotates left by r columns.
    for (genvar gi = 0; gi < 16; gi++) begin : g_shiftrows
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;
        assign sr[gi] = sb[ROW + 4 * ((COL + ROW) % 4)];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_mixcols
        logic [7:0] a0, a1, a2, a3;
        assign a0 = sr[4*gi];
        assign a1 = sr[4*gi+1];
        assign a2 = sr[4*gi+2];
        assign a3 = sr[4*gi+3];
        assign mc[4*gi]   = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        assign mc[4*gi+1] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        assign mc[4*gi+2] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        assign mc[4*gi+3] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_addkey
        assign round_out[127-8*gi -: 8] = (last_round ? sr[gi] : mc[gi]) ^ nk[127-8*gi -: 8];
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            fsm_reg <= IDLE;
        end else begin
            fsm_reg <= fsm_next;
        end
    end

    always_comb begin
        fsm_next = fsm_reg;
        Ready    = 1'b0;
        Busy     = 1'b0;
        case (fsm_reg)
            IDLE: begin
                if (Run) begin
                    fsm_next = ROUND;
                end
            end
            ROUND: begin
                Busy = 1'b1;
                if (last_round) begin
                    fsm_next = DONE;
                end
            end
            DONE: begin
                Ready = 1'b1;
                if (!Run) begin
                    fsm_next = IDLE;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            blk_reg <= '0;
            key_reg <= '0;
            ct_reg  <= '0;
            rnd_reg <= '0;
        end else begin
            case (fsm_reg)
                IDLE: begin
                    if (Run) begin
                        blk_reg <= Plaintext ^ Cipherkey;
                        key_reg <= Cipherkey;
                        rnd_reg <= 4'd1;
                    end
                end
                ROUND: begin
                    key_reg <= nk;
                    blk_reg <= round_out;
                    if (last_round) begin
                        ct_reg <= round_out;
                    end else begin
                        rnd_reg <= rnd_reg + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Ciphertext = ct_reg;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Scoreboard bench for aes_encrypt_core: driver pushes expected ciphertext and ready cycle,
// a negedge monitor pops and compares whenever Ready rises.
module tb_aes_encrypt_core;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         Run = 1'b0;
    logic [127:0] Plaintext = '0;
    logic [127:0] Cipherkey = '0;
    logic [127:0] Ciphertext;
    logic         Ready;
    logic         Busy;

    aes_encrypt_core #(.NR(10)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Run        (Run),
        .Plaintext  (Plaintext),
        .Cipherkey  (Cipherkey),
        .Ciphertext (Ciphertext),
        .Ready      (Ready),
        .Busy       (Busy)
    );

    always #5 Clk = ~Clk;

    int unsigned cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [127:0] ct;
        int unsigned  cyc;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] sbox_m [256];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box derived from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        for (int b = 0; b < 256; b++) begin
            logic [7:0] inv = 8'h00;
            if (b != 0) begin
                for (int x = 1; x < 256; x++) begin
                    if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
                end
            end
            sbox_m[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic aes_ref(input logic [127:0] pt, input logic [127:0] key,
                           output logic [127:0] ct, output logic [127:0] last_key);
        logic [31:0] w [44];
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [7:0]  rc = 8'h01;
        logic [31:0] tmp;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_m[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[row + 4*c] = t[row + 4*((c + row) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    logic [7:0] a0, a1, a2, a3;
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
                    s[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
        last_key = {w[40], w[41], w[42], w[43]};
    endtask

    // Called at a negedge with the core idle; returns after the start edge.
    task automatic start_op(input logic [127:0] pt, input logic [127:0] key,
                            input logic [127:0] exp_ct, input bit push);
        exp_t e;
        Plaintext = pt;
        Cipherkey = key;
        Run = 1'b1;
        @(posedge Clk);
        #1;
        if (push) begin
            e.ct = exp_ct;
            e.cyc = cyc + 10;
            exp_q.push_back(e);
        end
        @(negedge Clk);
        chk("busy_after_start", {127'h0, Busy}, 128'h1);
    endtask

    task automatic wait_ready(output int unsigned at);
        bit seen = 0;
        at = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (Ready) begin
                seen = 1;
                at = cyc;
            end else begin
                @(negedge Clk);
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=0 required=1 at cycle %0d", cyc);
        end
    endtask

    task automatic drop_run();
        Run = 1'b0;
        @(negedge Clk);
        chk("ready_after_drop", {127'h0, Ready}, 128'h0);
    endtask

    // Monitor: pop the scoreboard on each rising Ready; while Ready holds, result must not move.
    logic         ready_q = 1'b0;
    logic [127:0] held_ct = '0;
    always @(negedge Clk) begin
        if (Reset && Ready && !ready_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready actual=%h required=none", Ciphertext);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ciphertext", Ciphertext, e.ct);
                chk("ready_latency", 128'(cyc), 128'(e.cyc));
                held_ct = e.ct;
            end
        end else if (Reset && Ready && ready_q) begin
            chk("ciphertext_held", Ciphertext, held_ct);
        end
        ready_q = Ready;
    end

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    initial begin
        int unsigned r1, r2;
        logic [127:0] pt, key, ct, lk;

        build_sbox();

        repeat (3) @(negedge Clk);
        chk("reset_ready", {127'h0, Ready}, 128'h0);
        chk("reset_busy", {127'h0, Busy}, 128'h0);
        chk("reset_ciphertext", Ciphertext, 128'h0);
        Reset = 1'b1;
        @(negedge Clk);

        // FIPS-197 C.1
        start_op(C1_PT, C1_KEY, C1_CT, 1);
        wait_ready(r1);
        drop_run();

        // FIPS-197 appendix B, including the final round key
        start_op(B_PT, B_KEY, B_CT, 1);
        wait_ready(r1);
        chk("final_round_key", dut.key_reg, B_RK10);
        drop_run();

        // All-zero vector, Run held in DONE must not retrigger
        start_op('0, '0, Z_CT, 1);
        wait_ready(r1);
        repeat (20) begin
            @(negedge Clk);
            chk("held_ready", {127'h0, Ready}, 128'h1);
            chk("held_busy", {127'h0, Busy}, 128'h0);
        end
        drop_run();

        // Inputs change and Run drops during the rounds
        start_op(C1_PT, C1_KEY, C1_CT, 1);
        repeat (2) @(negedge Clk);
        Plaintext = '1;
        Cipherkey = '1;
        Run = 1'b0;
        wait_ready(r1);
        @(negedge Clk);
        chk("ready_one_cycle", {127'h0, Ready}, 128'h0);

        // Reset mid-operation aborts with no output
        start_op(C1_PT, C1_KEY, C1_CT, 0);
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        Run = 1'b0;
        @(negedge Clk);
        chk("abort_ready", {127'h0, Ready}, 128'h0);
        chk("abort_busy", {127'h0, Busy}, 128'h0);
        chk("abort_ciphertext", Ciphertext, 128'h0);
        Reset = 1'b1;
        @(negedge Clk);
        start_op(B_PT, B_KEY, B_CT, 1);
        wait_ready(r1);
        drop_run();

        // Back-to-back with a single Run-low cycle in DONE
        start_op(C1_PT, C1_KEY, C1_CT, 1);
        wait_ready(r1);
        Run = 1'b0;
        @(negedge Clk);
        start_op(B_PT, B_KEY, B_CT, 1);
        wait_ready(r2);
        chk("back_to_back_period", 128'(r2 - r1), 128'd12);
        drop_run();

        // Randomized vectors against the reference model
        for (int n = 0; n < 10; n++) begin
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            aes_ref(pt, key, ct, lk);
            start_op(pt, key, ct, 1);
            wait_ready(r1);
            chk("rand_round_key", dut.key_reg, lk);
            repeat ($urandom_range(0, 3)) @(negedge Clk);
            drop_run();
            repeat ($urandom_range(0, 2)) @(negedge Clk);
        end

        repeat (2) @(negedge Clk);
        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/aes_encrypt_core.md
Name: aes_encrypt_core

Overview:
- Iterative AES-128 encryption engine; the forward-direction counterpart of the team's existing inverse-round datapath.
- Accepts a 128-bit plaintext and cipher key under a Run/Ready level handshake.
- Computes one round per clock, generating each round key on the fly.
- Presents the 128-bit ciphertext with Ready held high until the requester drops Run.

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) is supported, and any other value is an elaboration error.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-low reset; sampled on the rising edge of Clk.
- Run  input  1  start request, level-sensitive.
- Plaintext  input  128  input block; bits [127:120] are state byte 0; FIPS-197 column-major order.
- Cipherkey  input  128  AES-128 key; same byte order as Plaintext.
- Ciphertext  output  128  registered result; same byte order.
- Ready  output  1  result valid.
- Busy  output  1  high while rounds are in progress.

Behaviour:
- Reset (Reset==0 at a rising edge):
  - FSM goes to IDLE.
  - Ready=0, Busy=0, Ciphertext=128'h0.
  - Round counter=0; state and key registers are cleared.
  - Reset overrides every other input and aborts any operation in flight with no partial output.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - Ready=0, Busy=0.
  - On an edge with Run==1:
    - state <= Plaintext ^ Cipherkey.
    - key <= Cipherkey.
    - rnd <= 1.
    - Go to ROUND.
  - Plaintext and Cipherkey are sampled only at this edge; later changes are ignored.
- ROUND:
  - Busy=1.
  - Each edge computes:
    - nk = KeyExpand(key, rcon[rnd]).
    - key <= nk.
    - state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), nk).
  - When rnd==NR, MixColumns is omitted. In that case:
    - Ciphertext is loaded with the round result.
    - Go to DONE.
  - Otherwise rnd <= rnd+1.
  - Run is ignored in ROUND, including deassertion mid-operation.
- rcon sequence for rnd 1..10: 01,02,04,08,10,20,40,80,1b,36.
- KeyExpand (FIPS-197):
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - w1' = w1 ^ w0'.
  - w2' = w2 ^ w1'.
  - w3' = w3 ^ w2'.
- Arithmetic:
  - MixColumns uses GF(2^8) modulo 0x11b.
  - xtime(b) = (b<<1) ^ (b[7] ? 8'h1b : 0).
- S-box: 20 forward S-box lookups per cycle (16 state + 4 key), all combinational; no extra latency.
- DONE:
  - Ready=1, Busy=0; Ciphertext is stable.
  - Stays in DONE while Run==1, so a held Run does not retrigger.
  - On an edge with Run==0: go to IDLE, and Ready falls.
- Ciphertext keeps its value until the next completion or a reset.
- Latency: Run sampled high at edge N gives Ready=1 after edge N+10.
- Minimum back-to-back period is 12 cycles: 10 rounds, one DONE cycle with Run low, and one IDLE start edge.
- Run high at the same edge that leaves DONE is not possible, because the DONE→IDLE transition requires Run==0. A new start is accepted at the following edge.

Test Plan:
- FIPS-197 C.1: Cipherkey=000102030405060708090a0b0c0d0e0f, Plaintext=00112233445566778899aabbccddeeff, Run pulse held -> Ready after exactly 10 edges past the start edge; Ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; the internal key after round 10 equals d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key and plaintext -> 66e94bd4ef8a2c3b884cfa59ca342b2e. Then hold Run high for 20 cycles -> Ready stays 1, no retrigger, and Ciphertext does not change. Drop Run -> Ready=0 the next cycle.
- Input change mid-run: start C.1, then at round 4 change Plaintext/Cipherkey to all-F and drop Run -> the result is still 69c4e0d8...c55a at the same cycle.
- Reset mid-operation: start C.1, assert Reset=0 at round 5 -> next edge Ready=0, Busy=0, Ciphertext=0. Release reset, start the B vector -> correct B result with nominal latency.
- Back-to-back: C.1 then B with Run dropped for one cycle in DONE -> both results correct; the second Ready asserts 12 cycles after the first.
